fp_normalize_seq: RTL

FP_NORMALIZE_SEQ -- requirements
Module: fp_normalize_seq

---
 rtl/fp_normalize_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_normalize_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_normalize_seq
//  Purpose  : Multi-cycle floating-point mantissa normalizer. Accepts an
//             unnormalized mantissa (with carry and hidden bit) plus a biased
//             exponent, then normalizes it. A carry costs one right shift.
//             Leading zeros cost left shifts of at most SHIFT_STEP bits per
//             cycle, and left shifts stop once the exponent reaches its
//             minimum. The result is reported with overflow, underflow,
//             zero, inexact and shifted flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_normalize_seq #(
  parameter int MANT_W     = 49,   // [MANT_W-1] carry, [MANT_W-2] hidden bit
  parameter int EXP_W      = 9,
  parameter int SHIFT_STEP = 8,    // maximum left shift per cycle
  parameter int MAX_EXP_H  = 30,   // half-precision maximum exponent
  parameter int MAX_EXP_S  = 254   // single-precision maximum exponent
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              MODE_FP,
  input  logic [MANT_W-1:0] MANT,
  input  logic [EXP_W-1:0]  EXP,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant,
  output logic [EXP_W-1:0]  exp,
  output logic [4:0]        FLAGS
);

  // Smallest exponent a left shift may reach.
  localparam int MIN_EXP = 1;
  // Width that can hold a leading-zero count over the hidden bit and below.
  localparam int LZ_W    = $clog2(MANT_W);

  // Flag bit positions.
  localparam int F_OVF = 4;
  localparam int F_UNF = 3;
  localparam int F_ZERO = 2;
  localparam int F_INEX = 1;
  localparam int F_SHIFT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  // The working registers double as the visible result registers.
  logic [MANT_W-1:0]   r_mant;
  logic [EXP_W-1:0]    r_exp;
  logic [4:0]          r_flags;
  logic                r_mode;

  logic [MANT_W-1:0]   w_mant_nx;
  logic [EXP_W-1:0]    w_exp_nx;
  logic [4:0]          w_flags_nx;
  logic                w_mode_nx;

  logic [LZ_W-1:0]     w_lz;
  logic                w_found;
  logic [31:0]         w_room;
  logic [31:0]         w_k;
  logic [EXP_W-1:0]    w_max_exp;
  logic                w_exit;

  assign mant      = r_mant;
  assign exp       = r_exp;
  assign FLAGS     = r_flags;
  // in_ready also drops while reset is held, so nothing is accepted in reset.
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == DONE);

  // The overflow threshold depends on the precision latched with the operand.
  assign w_max_exp = r_mode ? EXP_W'(MAX_EXP_S) : EXP_W'(MAX_EXP_H);

  // Count zeros from the hidden bit downward to the first set bit.
  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = MANT_W - 2; i >= 0; i--) begin
      if (!w_found) begin
        if (r_mant[i]) begin
          w_found = 1'b1;
        end else begin
          w_lz = w_lz + LZ_W'(1);
        end
      end
    end
  end

  // Left-shift amount for this cycle: limited by leading zeros, the per-cycle
  // step, and the exponent headroom above MIN_EXP.
  always_comb begin
    if (r_exp > EXP_W'(MIN_EXP)) begin
      w_room = 32'(r_exp) - 32'(MIN_EXP);
    end else begin
      w_room = 32'd0;
    end
    w_k = 32'(w_lz);
    if (w_k > 32'(SHIFT_STEP)) begin
      w_k = 32'(SHIFT_STEP);
    end
    if (w_k > w_room) begin
      w_k = w_room;
    end
  end

  // State register; reset discards any operand in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Datapath registers; cleared while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mant  <= '0;
      r_exp   <= '0;
      r_flags <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_mant  <= w_mant_nx;
      r_exp   <= w_exp_nx;
      r_flags <= w_flags_nx;
      r_mode  <= w_mode_nx;
    end
  end

  // Next-state and datapath update for accept, normalize step and handshake.
  always_comb begin
    w_state_nx = r_state;
    w_mant_nx  = r_mant;
    w_exp_nx   = r_exp;
    w_flags_nx = r_flags;
    w_mode_nx  = r_mode;
    w_exit     = 1'b0;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_mant_nx  = MANT;
          w_exp_nx   = EXP;
          w_mode_nx  = MODE_FP;
          w_flags_nx = '0;
          w_state_nx = SHIFT;
        end
      end

      SHIFT: begin
        if (r_mant[MANT_W-1]) begin
          // Carry out: one right shift, the dropped bit marks inexact.
          w_mant_nx          = r_mant >> 1;
          w_flags_nx[F_INEX] = r_mant[0];
          if (&r_exp) begin
            // Exponent cannot grow past all-ones; saturate and flag it.
            w_exp_nx          = r_exp;
            w_flags_nx[F_OVF] = 1'b1;
          end else begin
            w_exp_nx = r_exp + EXP_W'(1);
          end
          if (w_exp_nx > w_max_exp) begin
            w_flags_nx[F_OVF] = 1'b1;
          end
          w_state_nx = DONE;
        end else if (r_mant == '0) begin
          // Zero is exclusive of every other flag.
          w_flags_nx = '0;
          w_flags_nx[F_ZERO] = 1'b1;
          w_state_nx = DONE;
        end else begin
          w_mant_nx = r_mant << w_k;
          w_exp_nx  = r_exp - w_k[EXP_W-1:0];
          if (w_k != 32'd0) begin
            w_flags_nx[F_SHIFT] = 1'b1;
          end
          w_exit = w_mant_nx[MANT_W-2] ||
                   (w_exp_nx <= EXP_W'(MIN_EXP)) ||
                   (w_k == 32'd0);
          if (w_exit) begin
            // Hidden bit still clear at exit means we ran out of exponent.
            w_flags_nx[F_UNF] = ~w_mant_nx[MANT_W-2];
            w_flags_nx[F_OVF] = (w_exp_nx > w_max_exp);
            w_state_nx        = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          w_state_nx = IDLE;
        end
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
